dcache_direct_mapped: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the core's data-memory port (load/store address, write data, write enable) and a slower backing data memory that uses a req/ready handshake.
- Hits complete in the same cycle with no stall.
- Misses and all stores raise `stall` until the backing memory answers. While `stall` is high the core freezes its PC and holds its request.

---
 rtl/dcache_direct_mapped_if.sv | 30 +++
 rtl/dcache_direct_mapped.sv | 162 ++++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_direct_mapped_if.sv
// Core/backing-memory bus bundle for dcache_direct_mapped.
// slave modport: the cache view (core request + memory response in, load data,
// stall and memory request out). master modport: the core + backing-memory view.
interface dcache_direct_mapped_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  stall;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  addr, write_data, write_enable, read_enable, mem_ready, mem_rdata,
    output read_data, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output addr, write_data, write_enable, read_enable, mem_ready, mem_rdata,
    input  read_data, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Load hits return data in the same cycle; load misses and all stores raise stall
// until the backing memory answers with mem_ready.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        dcache_direct_mapped_if.slave (core request/response + backing memory)
//   hit_count, miss_count  (only with DCACHE_STATS_EN) saturating 32-bit counters
// Optional feature macro: DCACHE_STATS_EN.
// stall, read_data and the mem_* outputs are combinational from the state register
// and the held core request, so hits and mem_ready completions take effect at once.
module dcache_direct_mapped #(
  parameter int unsigned N_LINES    = 16,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  dcache_direct_mapped_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDX_W = $clog2(N_LINES);
  localparam int unsigned TAG_W = ADDR_WIDTH - IDX_W - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [N_LINES-1:0]    valid_q;
  logic [TAG_W-1:0]      tag_q  [N_LINES];
  logic [DATA_WIDTH-1:0] data_q [N_LINES];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  fill_c;
  logic                  update_c;
  logic                  hit_event_c;
  logic                  stall_c;
  logic [DATA_WIDTH-1:0] read_data_c;
  logic                  mem_req_c;
  logic                  mem_we_c;
  logic                  unused_addr_bits;

  // Address split: byte offset bits are ignored, word accesses only.
  assign idx              = bus.addr[IDX_W+1:2];
  assign tag              = bus.addr[ADDR_WIDTH-1:IDX_W+2];
  assign hit              = valid_q[idx] && (tag_q[idx] == tag);
  assign unused_addr_bits = ^bus.addr[1:0];

  // Next state and outputs; reset forces every output to its idle value.
  always_comb begin
    state_d     = state_q;
    stall_c     = 1'b0;
    read_data_c = '0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    fill_c      = 1'b0;
    update_c    = 1'b0;
    hit_event_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.write_enable) begin
          // Store wins over a simultaneous load.
          state_d = WRITE;
          stall_c = 1'b1;
        end else if (bus.read_enable && !hit) begin
          state_d = FILL;
          stall_c = 1'b1;
        end else if (bus.read_enable) begin
          read_data_c = data_q[idx];
          hit_event_c = 1'b1;
        end
      end
      FILL: begin
        mem_req_c = 1'b1;
        stall_c   = !bus.mem_ready;
        if (bus.mem_ready) begin
          // Bypass the returning word so the core advances this cycle.
          read_data_c = bus.mem_rdata;
          fill_c      = 1'b1;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        stall_c   = !bus.mem_ready;
        if (bus.mem_ready) begin
          update_c = hit;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      stall_c     = 1'b0;
      read_data_c = '0;
      mem_req_c   = 1'b0;
      mem_we_c    = 1'b0;
      fill_c      = 1'b0;
      update_c    = 1'b0;
      hit_event_c = 1'b0;
    end
  end

  // State register and valid bits; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_c) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays need no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= bus.mem_rdata;
    end else if (update_c) begin
      data_q[idx] <= bus.write_data;
    end
  end

  assign bus.stall     = stall_c;
  assign bus.read_data = read_data_c;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_wdata = bus.write_data;

`ifdef DCACHE_STATS_EN
  // Saturating hit/miss counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_event_c && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (fill_c && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Self-checking bench for dcache_direct_mapped: directed scenarios plus random
// loads/stores against an address-level cache model and a backing-memory responder.
module tb_dcache_direct_mapped;
  localparam int unsigned N_LINES = 16;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;

  typedef logic [31:0] word_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  dcache_direct_mapped_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_direct_mapped #(.N_LINES(N_LINES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core must hold its request while stalled.
  a_hold_while_stalled: assert property (@(posedge clk) disable iff (rst)
    bus.stall |=> ($stable(bus.write_enable) && $stable(bus.read_enable) && $stable(bus.addr)));

  // Backing memory (driven by DUT writes) and the model's view of memory.
  word_t backing [word_t];
  word_t ref_mem [word_t];
  word_t ref_line [int];

  function automatic word_t mem_init(word_t w);
    return w ^ 32'h5A5A_C3C3;
  endfunction

  function automatic word_t back_read(word_t w);
    return backing.exists(w) ? backing[w] : mem_init(w);
  endfunction

  function automatic word_t ref_read(word_t w);
    return ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
  endfunction

  function automatic word_t word_of(word_t a);
    return a & ~32'h3;
  endfunction

  function automatic int line_of(word_t a);
    return int'((a >> 2) % N_LINES);
  endfunction

  function automatic bit ref_hit(word_t a);
    return ref_line.exists(line_of(a)) && (ref_line[line_of(a)] == word_of(a));
  endfunction

  // Model: predict stall cycles, load data and memory request cycles; update state.
  function automatic void model_step(input bit wr, input word_t a, input word_t wd,
                                     input int wait_n, output int exp_st,
                                     output word_t exp_rd, output int exp_req);
    if (wr) begin
      exp_st  = wait_n;
      exp_rd  = '0;
      exp_req = wait_n;
      ref_mem[word_of(a)] = wd;
    end else if (ref_hit(a)) begin
      exp_st  = 0;
      exp_rd  = ref_read(word_of(a));
      exp_req = 0;
    end else begin
      exp_st  = wait_n;
      exp_rd  = ref_read(word_of(a));
      exp_req = wait_n;
      ref_line[line_of(a)] = word_of(a);
    end
  endfunction

  // Drive one access (entered just after posedge) and act as the backing memory;
  // mem_ready rises in the wait_n-th mem_req cycle. Returns just after the next posedge.
  task automatic access(input bit wr, input bit re, input word_t a, input word_t wd,
                        input int wait_n, output int stalls, output word_t rdata,
                        output int req_cycles, output bit bus_bad);
    int nreq;
    bit done;
    stalls = 0; nreq = 0; bus_bad = 1'b0; rdata = '0; done = 1'b0;
    bus.addr = a; bus.write_data = wd; bus.write_enable = wr; bus.read_enable = re;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      #1;
      if (bus.mem_req === 1'b1) begin
        nreq++;
        if (bus.mem_we !== wr || bus.mem_addr !== word_of(a) ||
            (wr && bus.mem_wdata !== wd)) bus_bad = 1'b1;
        bus.mem_ready = (nreq >= wait_n);
        bus.mem_rdata = bus.mem_ready ? back_read(bus.mem_addr) : word_t'($urandom);
      end else begin
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = word_t'($urandom);
      end
      @(negedge clk);
      if (bus.stall === 1'b0) begin
        done  = 1'b1;
        rdata = bus.read_data;
        if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) backing[bus.mem_addr] = bus.mem_wdata;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    req_cycles = nreq;
    if (!done) stalls = -1;
  endtask

  task automatic idle();
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.mem_ready    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.mem_ready    = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_line.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_in_rst got %b want 0", bus.mem_req); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
    n_cmp++;
    if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %b want 0", bus.mem_we); end
    n_cmp++;
    if (bus.read_data !== '0) begin n_fail++; $display("FAIL reset_read_data got %h want 0", bus.read_data); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_cold_miss();
    int st, rq; word_t rd; bit bad;
    backing[32'h40] = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    access(1'b0, 1'b1, 32'h40, '0, 3, st, rd, rq, bad);
    ref_line[line_of(32'h40)] = 32'h40;
    n_cmp++;
    if (st !== 3) begin n_fail++; $display("FAIL cold_miss_stalls got %0d want 3", st); end
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cold_miss_data got %h want deadbeef", rd); end
    n_cmp++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL cold_miss_bus got %b want 0", bad); end
    access(1'b0, 1'b1, 32'h40, '0, 1, st, rd, rq, bad);
    n_cmp++;
    if (st !== 0 || rq !== 0) begin n_fail++; $display("FAIL cold_rehit_stalls got %0d/%0d want 0/0", st, rq); end
    n_cmp++;
    if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cold_rehit_data got %h want deadbeef", rd); end
  endtask

  task automatic test_store_hit();
    int st, rq; word_t rd; bit bad;
    access(1'b1, 1'b0, 32'h40, 32'h1234_5678, 1, st, rd, rq, bad);
    ref_mem[32'h40] = 32'h1234_5678;
    n_cmp++;
    if (st !== 1 || rq !== 1) begin n_fail++; $display("FAIL store_hit_stalls got %0d/%0d want 1/1", st, rq); end
    n_cmp++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL store_hit_bus got %b want 0", bad); end
    n_cmp++;
    if (back_read(32'h40) !== 32'h1234_5678) begin
      n_fail++; $display("FAIL store_hit_writethrough got %h want 12345678", back_read(32'h40));
    end
    access(1'b0, 1'b1, 32'h40, '0, 1, st, rd, rq, bad);
    n_cmp++;
    if (st !== 0) begin n_fail++; $display("FAIL store_hit_reread_stalls got %0d want 0", st); end
    n_cmp++;
    if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL store_hit_reread_data got %h want 12345678", rd); end
  endtask

  task automatic test_store_miss();
    int st, rq; word_t rd; bit bad;
    access(1'b1, 1'b0, 32'h80, 32'hAAAA_5555, 2, st, rd, rq, bad);
    ref_mem[32'h80] = 32'hAAAA_5555;
    n_cmp++;
    if (st !== 2 || bad !== 1'b0) begin n_fail++; $display("FAIL store_miss_write got %0d/%b want 2/0", st, bad); end
    access(1'b0, 1'b1, 32'h80, '0, 1, st, rd, rq, bad);
    ref_line[line_of(32'h80)] = 32'h80;
    n_cmp++;
    if (st !== 1 || rq !== 1) begin n_fail++; $display("FAIL store_miss_noalloc got %0d/%0d want 1/1", st, rq); end
    n_cmp++;
    if (bad !== 1'b0 || rd !== 32'hAAAA_5555) begin
      n_fail++; $display("FAIL store_miss_read got %h/%b want aaaa5555/0", rd, bad);
    end
  endtask

  task automatic test_conflict();
    int st, rq; word_t rd; bit bad;
    word_t seq [3];
    seq[0] = 32'h40; seq[1] = 32'h80; seq[2] = 32'h40;
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b1, seq[i], '0, 2, st, rd, rq, bad);
      ref_line[line_of(seq[i])] = seq[i];
      n_cmp++;
      if (st !== 2 || rq !== 2 || rd !== ref_read(seq[i])) begin
        n_fail++; $display("FAIL conflict_%0d got %0d/%0d/%h want 2/2/%h", i, st, rq, rd, ref_read(seq[i]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int st, rq; word_t rd; bit bad;
    access(1'b0, 1'b1, 32'h300, '0, 1, st, rd, rq, bad);
    ref_line[line_of(32'h300)] = 32'h300;
    n_cmp++;
    if (st !== 1 || rd !== ref_read(32'h300)) begin n_fail++; $display("FAIL b2b_fill got %0d/%h want 1/%h", st, rd, ref_read(32'h300)); end
    access(1'b0, 1'b1, 32'h300, '0, 1, st, rd, rq, bad);
    n_cmp++;
    if (st !== 0 || rd !== ref_read(32'h300)) begin n_fail++; $display("FAIL b2b_hit got %0d/%h want 0/%h", st, rd, ref_read(32'h300)); end
    access(1'b1, 1'b0, 32'h300, 32'hCAFE_0001, 1, st, rd, rq, bad);
    ref_mem[32'h300] = 32'hCAFE_0001;
    n_cmp++;
    if (st !== 1 || rq !== 1 || bad !== 1'b0) begin n_fail++; $display("FAIL b2b_store got %0d/%0d/%b want 1/1/0", st, rq, bad); end
    access(1'b0, 1'b1, 32'h300, '0, 1, st, rd, rq, bad);
    n_cmp++;
    if (st !== 0 || rd !== 32'hCAFE_0001) begin n_fail++; $display("FAIL b2b_reread got %0d/%h want 0/cafe0001", st, rd); end
    idle();
  endtask

  task automatic test_reset_mid_fill();
    int st, rq; word_t rd; bit bad;
    bus.addr = 32'h100; bus.read_enable = 1'b1; bus.write_enable = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL rmf_start_stall got %b want 1", bus.stall); end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rmf_fill_req got %b want 1", bus.mem_req); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.read_enable = 1'b0;
    ref_line.delete();
    @(negedge clk);
    n_cmp++;
    if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rmf_req_after_rst got %b want 0", bus.mem_req); end
    @(posedge clk);
    #1;
    access(1'b0, 1'b1, 32'h100, '0, 2, st, rd, rq, bad);
    ref_line[line_of(32'h100)] = 32'h100;
    n_cmp++;
    if (st !== 2 || rq !== 2) begin n_fail++; $display("FAIL rmf_refill got %0d/%0d want 2/2", st, rq); end
    access(1'b0, 1'b1, 32'h40, '0, 1, st, rd, rq, bad);
    ref_line[line_of(32'h40)] = 32'h40;
    n_cmp++;
    if (st !== 1) begin n_fail++; $display("FAIL rmf_valid_cleared got %0d want 1", st); end
  endtask

  task automatic test_random();
    int st, rq, wait_n, exp_st, exp_req; word_t rd, a, wd, exp_rd; bit bad, wr, re;
    for (int i = 0; i < 150; i++) begin
      wr = ($urandom_range(0, 3) == 0);
      re = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      a  = (word_t'($urandom_range(0, 3)) << 6) | (word_t'($urandom_range(0, 15)) << 2) |
           word_t'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a[31] = 1'b1;
      wd = word_t'($urandom);
      wait_n = $urandom_range(1, 4);
      model_step(wr, a, wd, wait_n, exp_st, exp_rd, exp_req);
      access(wr, re, a, wd, wait_n, st, rd, rq, bad);
      n_cmp++;
      if (st !== exp_st || rq !== exp_req) begin
        n_fail++; $display("FAIL rand_%0d_timing a=%h got %0d/%0d want %0d/%0d", i, a, st, rq, exp_st, exp_req);
      end
      n_cmp++;
      if (rd !== exp_rd) begin n_fail++; $display("FAIL rand_%0d_data a=%h got %h want %h", i, a, rd, exp_rd); end
      n_cmp++;
      if (bad !== 1'b0) begin n_fail++; $display("FAIL rand_%0d_bus a=%h got %b want 0", i, a, bad); end
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
  endtask

`ifdef DCACHE_STATS_EN
  task automatic test_stats();
    int st, rq; word_t rd; bit bad;
    do_reset();
    n_cmp++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++; $display("FAIL stats_reset got %0d/%0d want 0/0", hit_count, miss_count);
    end
    access(1'b0, 1'b1, 32'h400, '0, 1, st, rd, rq, bad);
    access(1'b0, 1'b1, 32'h400, '0, 1, st, rd, rq, bad);
    access(1'b0, 1'b1, 32'h400, '0, 1, st, rd, rq, bad);
    access(1'b0, 1'b1, 32'h404, '0, 2, st, rd, rq, bad);
    access(1'b0, 1'b1, 32'h404, '0, 1, st, rd, rq, bad);
    idle();
    n_cmp++;
    if (hit_count !== 32'd3) begin n_fail++; $display("FAIL stats_hits got %0d want 3", hit_count); end
    n_cmp++;
    if (miss_count !== 32'd2) begin n_fail++; $display("FAIL stats_misses got %0d want 2", miss_count); end
    do_reset();
    n_cmp++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++; $display("FAIL stats_rst_clear got %0d/%0d want 0/0", hit_count, miss_count);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.addr = '0;
    bus.write_data = '0;
    bus.write_enable = 1'b0;
    bus.read_enable = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_cold_miss();
    test_store_hit();
    test_store_miss();
    test_conflict();
    test_back_to_back();
    test_reset_mid_fill();
    test_random();
`ifdef DCACHE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
